// File: rtl/conv_pkg.sv
// Shared types and constants for the RGB convolution datapath.
// rgb_pixel_t is the pixel layout seen by the convolution stage.
package conv_pkg;

   localparam int unsigned PIXEL_W = 96;
   localparam int unsigned COORD_W = 16;

   typedef struct packed {
      logic signed [31:0] r;
      logic signed [31:0] g;
      logic signed [31:0] b;
   } rgb_pixel_t;

endpackage

// File: rtl/line_buffer.sv
// One-line delay buffer: DEPTH entries of WIDTH bits, read and written at the
// same address. The read is combinational, so rdata in the write cycle is the
// entry stored one line earlier (read-before-write).
//   clk   : clock
//   en    : write enable (one pixel accepted)
//   addr  : column address
//   wdata : value stored at addr
//   rdata : old value at addr
module line_buffer #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; stale entries are masked upstream.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/sliding_window_buffer.sv
// KxK sliding window generator for a raster-order RGB pixel stream.
// Keeps KERNEL_SIZE-1 previous lines and emits a registered window for every
// accepted pixel whose window lies fully inside the image.
//   clk, reset  : clock, synchronous active-high reset
//   in_pixel    : incoming pixel {r,g,b}
//   in_sof      : pixel is row 0, col 0 of a new frame
//   in_valid    : in_pixel/in_sof valid
//   in_ready    : pixel accepted this cycle when in_valid
//   out_window  : [0][0] oldest (top-left), [K-1][K-1] newest pixel
//   out_valid   : out_window valid
//   out_ready   : downstream takes the window
//   out_row/col : image coordinates of out_window[K-1][K-1]
module sliding_window_buffer #(
   parameter int unsigned KERNEL_SIZE = 3,
   parameter int unsigned IMG_WIDTH   = 640,
   parameter int unsigned PIXEL_W     = conv_pkg::PIXEL_W
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [PIXEL_W-1:0]                                 in_pixel,
   input  logic                                               in_sof,
   input  logic                                               in_valid,
   output logic                                               in_ready,
   output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_W-1:0] out_window,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic [conv_pkg::COORD_W-1:0]                       out_row,
   output logic [conv_pkg::COORD_W-1:0]                       out_col
);
   import conv_pkg::*;

   localparam int unsigned K  = KERNEL_SIZE;
   localparam int unsigned AW = $clog2(IMG_WIDTH);

   logic [K-1:0][K-1:0][PIXEL_W-1:0] window_q, window_d;
   logic                             out_valid_q, out_valid_d;
   logic [COORD_W-1:0]               row_q, row_d, col_q, col_d;
   logic [COORD_W-1:0]               out_row_q, out_row_d, out_col_q, out_col_d;

   logic                             accept, qualify;
   logic [COORD_W-1:0]               pix_row, pix_col;
   logic [K-2:0][PIXEL_W-1:0]        lb_wdata, lb_rdata;
   logic [K-1:0][PIXEL_W-1:0]        new_col;

   // One-deep output register: input stalls only while a window is held.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // in_sof overrides the counters so a partial line is simply abandoned.
   assign pix_row = in_sof ? '0 : row_q;
   assign pix_col = in_sof ? '0 : col_q;
   assign qualify = (pix_row >= COORD_W'(K - 1)) && (pix_col >= COORD_W'(K - 1));

   // Line buffers chain: buffer i delays buffer i-1 by one more line.
   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      if (i == 0) begin : g_head
         assign lb_wdata[i] = in_pixel;
      end else begin : g_chain
         assign lb_wdata[i] = lb_rdata[i-1];
      end
      line_buffer #(
         .DEPTH (IMG_WIDTH),
         .WIDTH (PIXEL_W)
      ) u_line_buffer (
         .clk   (clk),
         .en    (accept),
         .addr  (pix_col[AW-1:0]),
         .wdata (lb_wdata[i]),
         .rdata (lb_rdata[i])
      );
   end

   // Newest column: bottom row is the live pixel, row 0 the oldest line.
   for (genvar r = 0; r < K; r++) begin : g_new_col
      if (r == K - 1) begin : g_live
         assign new_col[r] = in_pixel;
      end else begin : g_buf
         assign new_col[r] = lb_rdata[K-2-r];
      end
   end

   always_comb begin
      row_d       = row_q;
      col_d       = col_q;
      window_d    = window_q;
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (pix_col == COORD_W'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = (pix_row == '1) ? pix_row : pix_row + COORD_W'(1);
         end else begin
            col_d = pix_col + COORD_W'(1);
            row_d = pix_row;
         end

         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) begin
               window_d[r][c] = window_q[r][c+1];
            end
            window_d[r][K-1] = new_col[r];
         end

         if (qualify) begin
            out_valid_d = 1'b1;
            out_row_d   = pix_row;
            out_col_d   = pix_col;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q       <= '0;
         col_q       <= '0;
         window_q    <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else begin
         row_q       <= row_d;
         col_q       <= col_d;
         window_q    <= window_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
      end
   end

   assign out_window = window_q;
   assign out_valid  = out_valid_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer: a small (K=3, width 4) instance for the
// scenario tests and a full-width (K=5, width 640) instance. Expected windows
// are cut directly out of a stored copy of the image.
module tb_sliding_window_buffer;
   import conv_pkg::*;

   localparam int KA = 3;
   localparam int WA = 4;
   localparam int KB = 5;
   localparam int WB = 640;

   typedef logic [KA-1:0][KA-1:0][95:0] win_a_t;
   typedef logic [KB-1:0][KB-1:0][95:0] win_b_t;
   typedef struct {int row; int col; win_a_t win;} rec_a_t;
   typedef struct {int row; int col; win_b_t win;} rec_b_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [95:0] a_in_pixel = '0;
   logic        a_in_sof = 1'b0, a_in_valid = 1'b0, a_in_ready;
   win_a_t      a_out_window;
   logic        a_out_valid, a_out_ready = 1'b1;
   logic [15:0] a_out_row, a_out_col;

   logic [95:0] b_in_pixel = '0;
   logic        b_in_sof = 1'b0, b_in_valid = 1'b0, b_in_ready;
   win_b_t      b_out_window;
   logic        b_out_valid, b_out_ready = 1'b1;
   logic [15:0] b_out_row, b_out_col;

   sliding_window_buffer #(.KERNEL_SIZE(KA), .IMG_WIDTH(WA), .PIXEL_W(96)) u_dut_a (
      .clk(clk), .reset(reset), .in_pixel(a_in_pixel), .in_sof(a_in_sof),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .out_window(a_out_window),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_row(a_out_row),
      .out_col(a_out_col)
   );

   sliding_window_buffer #(.KERNEL_SIZE(KB), .IMG_WIDTH(WB), .PIXEL_W(96)) u_dut_b (
      .clk(clk), .reset(reset), .in_pixel(b_in_pixel), .in_sof(b_in_sof),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .out_window(b_out_window),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
      .out_col(b_out_col)
   );

   int tests_run = 0;
   int tests_failed = 0;

   logic [95:0] img_a [0:7][0:WA-1];
   logic [95:0] img_b [0:5][0:WB-1];
   rec_a_t exp_a[$], got_a[$];
   rec_b_t exp_b[$], got_b[$];
   bit prev_valid_a = 1'b0, consec_a = 1'b0;

   // Output monitors: record every transfer (out_valid && out_ready at the edge).
   always @(negedge clk) begin
      rec_a_t ra;
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
         ra.row = int'(a_out_row);
         ra.col = int'(a_out_col);
         ra.win = a_out_window;
         got_a.push_back(ra);
      end
      if (a_out_valid === 1'b1 && prev_valid_a) consec_a = 1'b1;
      prev_valid_a = (a_out_valid === 1'b1);
   end

   always @(negedge clk) begin
      rec_b_t rb;
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
         rb.row = int'(b_out_row);
         rb.col = int'(b_out_col);
         rb.win = b_out_window;
         got_b.push_back(rb);
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit hit, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [95:0] mk(input int r, input int g, input int b);
      return {r[31:0], g[31:0], b[31:0]};
   endfunction

   function automatic win_a_t build_win_a(input int row, input int col);
      win_a_t w;
      for (int r = 0; r < KA; r++)
         for (int c = 0; c < KA; c++)
            w[r][c] = img_a[row-KA+1+r][col-KA+1+c];
      return w;
   endfunction

   function automatic win_b_t build_win_b(input int row, input int col);
      win_b_t w;
      for (int r = 0; r < KB; r++)
         for (int c = 0; c < KB; c++)
            w[r][c] = img_b[row-KB+1+r][col-KB+1+c];
      return w;
   endfunction

   // -1 on length difference, else number of differing records.
   function automatic int diff_a();
      int bad = 0;
      if (got_a.size() != exp_a.size()) return -1;
      foreach (got_a[i])
         if (got_a[i].row != exp_a[i].row || got_a[i].col != exp_a[i].col ||
             got_a[i].win !== exp_a[i].win) bad++;
      return bad;
   endfunction

   task automatic clear_a();
      exp_a.delete();
      got_a.delete();
      consec_a = 1'b0;
   endtask

   task automatic idle_a(input int n);
      a_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Offers one pixel until accepted; row/col are its true image position.
   task automatic drive_a(input logic [95:0] pix, input logic sof, input int row, input int col);
      int guard = 0;
      bit done = 1'b0;
      a_in_pixel = pix;
      a_in_sof   = sof;
      a_in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (a_in_ready === 1'b1) begin
            rec_a_t e;
            img_a[row][col] = pix;
            if (row >= KA - 1 && col >= KA - 1) begin
               e.row = row;
               e.col = col;
               e.win = build_win_a(row, col);
               exp_a.push_back(e);
            end
            done = 1'b1;
         end else if (guard >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drive_a_timeout: in_ready=%b, required 1", a_in_ready);
            done = 1'b1;
         end
         guard++;
         @(posedge clk);
         #1;
      end
      a_in_valid = 1'b0;
      a_in_sof   = 1'b0;
   endtask

   task automatic drive_b(input logic [95:0] pix, input logic sof, input int row, input int col);
      int guard = 0;
      bit done = 1'b0;
      b_in_pixel = pix;
      b_in_sof   = sof;
      b_in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (b_in_ready === 1'b1) begin
            rec_b_t e;
            img_b[row][col] = pix;
            if (row >= KB - 1 && col >= KB - 1) begin
               e.row = row;
               e.col = col;
               e.win = build_win_b(row, col);
               exp_b.push_back(e);
            end
            done = 1'b1;
         end else if (guard >= 200) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drive_b_timeout: in_ready=%b, required 1", b_in_ready);
            done = 1'b1;
         end
         guard++;
         @(posedge clk);
         #1;
      end
      b_in_valid = 1'b0;
      b_in_sof   = 1'b0;
   endtask

   // Pixels first..last-1 of a width-4 frame, r = base + 4*row + col, g = -r, b = 1.
   task automatic send_frame_a(input int base, input int first, input int last,
                               input bit sof_first, input bit gap);
      for (int n = first; n < last; n++) begin
         int v = base + WA * (n / WA) + (n % WA);
         drive_a(mk(v, -v, 1), (n == first) && sof_first, n / WA, n % WA);
         if (gap) idle_a(1);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      // A pixel offered during reset must be dropped.
      a_in_pixel = mk(77, 77, 77);
      a_in_valid = 1'b1;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_out_valid: got %b, required 0", a_out_valid);
      end
      tests_run++;
      if (a_out_window !== '0) begin
         tests_failed++;
         $display("FAIL reset_out_window: got %h, required 0", a_out_window);
      end
      tests_run++;
      if (a_out_row !== 16'd0 || a_out_col !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_coords: got (%0d,%0d), required (0,0)", a_out_row, a_out_col);
      end
      tests_run++;
      if (a_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b, required 1", a_in_ready);
      end
      tests_run++;
      if (b_out_valid !== 1'b0 || b_out_window !== '0) begin
         tests_failed++;
         $display("FAIL reset_b_outputs: valid %b, required 0 with zero window", b_out_valid);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      a_in_valid = 1'b0;
   endtask

   task automatic test_basic();
      int rows_req [4] = '{2, 2, 3, 3};
      int cols_req [4] = '{2, 3, 2, 3};
      int d;
      rec_a_t f;
      clear_a();
      send_frame_a(0, 0, 16, 1'b0, 1'b0);  // first pixel without in_sof
      idle_a(3);
      d = diff_a();
      tests_run++;
      if (d !== 0) begin
         tests_failed++;
         $display("FAIL basic_model: got %0d bad records (%0d seen), required 0", d, got_a.size());
      end
      tests_run++;
      if (got_a.size() != 4) begin
         tests_failed++;
         $display("FAIL basic_count: got %0d windows, required 4", got_a.size());
      end
      for (int i = 0; i < 4 && i < got_a.size(); i++) begin
         tests_run++;
         if (got_a[i].row != rows_req[i] || got_a[i].col != cols_req[i]) begin
            tests_failed++;
            $display("FAIL basic_coord%0d: got (%0d,%0d), required (%0d,%0d)", i,
                     got_a[i].row, got_a[i].col, rows_req[i], cols_req[i]);
         end
      end
      if (got_a.size() > 0) begin
         logic signed [31:0] v00, v11, v22, g22;
         f = got_a[0];
         v00 = f.win[0][0][95:64];
         v11 = f.win[1][1][95:64];
         v22 = f.win[2][2][95:64];
         g22 = f.win[2][2][63:32];
         tests_run++;
         if (v00 !== 32'sd0 || v11 !== 32'sd5 || v22 !== 32'sd10) begin
            tests_failed++;
            $display("FAIL basic_first_r: got %0d/%0d/%0d, required 0/5/10", v00, v11, v22);
         end
         tests_run++;
         if (g22 !== -32'sd10) begin
            tests_failed++;
            $display("FAIL basic_first_g: got %0d, required -10", g22);
         end
      end
      tests_run++;
      if (consec_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_back_to_back: consecutive valid %b, required 1", consec_a);
      end
   endtask

   task automatic test_gaps();
      int d;
      clear_a();
      send_frame_a(0, 0, 16, 1'b1, 1'b1);
      idle_a(3);
      d = diff_a();
      tests_run++;
      if (d !== 0 || got_a.size() != 4) begin
         tests_failed++;
         $display("FAIL gaps_model: got %0d bad (%0d windows), required 0 bad of 4", d, got_a.size());
      end
      tests_run++;
      if (consec_a !== 1'b0) begin
         tests_failed++;
         $display("FAIL gaps_consecutive: consecutive valid %b, required 0", consec_a);
      end
   endtask

   task automatic test_backpressure();
      int d;
      clear_a();
      fork
         send_frame_a(0, 0, 16, 1'b1, 1'b0);
         begin
            int waited = 0;
            while (a_out_valid !== 1'b1 && waited < 200) begin
               @(posedge clk);
               #1;
               waited++;
            end
            tests_run++;
            if (a_out_valid !== 1'b1) begin
               tests_failed++;
               $display("FAIL bp_first_valid: out_valid %b, required 1", a_out_valid);
            end
            a_out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               tests_run++;
               if (a_in_ready !== 1'b0) begin
                  tests_failed++;
                  $display("FAIL bp_in_ready%0d: got %b, required 0", i, a_in_ready);
               end
               tests_run++;
               if (exp_a.size() == 0 || a_out_window !== exp_a[0].win ||
                   a_out_row !== 16'd2 || a_out_col !== 16'd2) begin
                  tests_failed++;
                  $display("FAIL bp_hold%0d: got (%0d,%0d) %h, required (2,2) window", i,
                           a_out_row, a_out_col, a_out_window);
               end
               @(posedge clk);
               #1;
            end
            a_out_ready = 1'b1;
         end
      join
      idle_a(3);
      d = diff_a();
      tests_run++;
      if (d !== 0 || got_a.size() != 4) begin
         tests_failed++;
         $display("FAIL bp_model: got %0d bad (%0d windows), required 0 bad of 4", d, got_a.size());
      end
   endtask

   task automatic test_sof_restart();
      int d;
      logic signed [31:0] v00, v22;
      clear_a();
      send_frame_a(0, 0, 10, 1'b1, 1'b0);    // 2.5 lines, then abandoned
      send_frame_a(100, 0, 16, 1'b1, 1'b0);
      idle_a(3);
      d = diff_a();
      tests_run++;
      if (d !== 0 || got_a.size() != 4) begin
         tests_failed++;
         $display("FAIL sof_model: got %0d bad (%0d windows), required 0 bad of 4", d, got_a.size());
      end
      if (got_a.size() > 0) begin
         v00 = got_a[0].win[0][0][95:64];
         v22 = got_a[0].win[2][2][95:64];
         tests_run++;
         if (got_a[0].row != 2 || got_a[0].col != 2 || v00 !== 32'sd100 || v22 !== 32'sd110) begin
            tests_failed++;
            $display("FAIL sof_first: got (%0d,%0d) r %0d/%0d, required (2,2) r 100/110",
                     got_a[0].row, got_a[0].col, v00, v22);
         end
      end
   endtask

   task automatic test_reset_mid();
      int d;
      logic signed [31:0] v22;
      clear_a();
      send_frame_a(0, 0, 12, 1'b1, 1'b0);    // ends with pixel (2,3)
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 1'b0 || a_out_window !== '0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: valid %b window %h, required 0 and 0",
                  a_out_valid, a_out_window);
      end
      d = diff_a();
      tests_run++;
      if (d !== 0 || got_a.size() != 2) begin
         tests_failed++;
         $display("FAIL midreset_pre: got %0d bad (%0d windows), required 0 bad of 2", d, got_a.size());
      end
      @(posedge clk);
      #1;
      clear_a();
      send_frame_a(200, 0, 10, 1'b0, 1'b0);
      idle_a(2);
      tests_run++;
      if (got_a.size() != 0) begin
         tests_failed++;
         $display("FAIL midreset_early: got %0d windows after 10 pixels, required 0", got_a.size());
      end
      send_frame_a(200, 10, 11, 1'b0, 1'b0);
      idle_a(2);
      tests_run++;
      if (got_a.size() != 1) begin
         tests_failed++;
         $display("FAIL midreset_11th: got %0d windows, required 1", got_a.size());
      end else begin
         v22 = got_a[0].win[2][2][95:64];
         tests_run++;
         if (got_a[0].row != 2 || got_a[0].col != 2 || v22 !== 32'sd210) begin
            tests_failed++;
            $display("FAIL midreset_first: got (%0d,%0d) r %0d, required (2,2) r 210",
                     got_a[0].row, got_a[0].col, v22);
         end
      end
      send_frame_a(200, 11, 16, 1'b0, 1'b0);
      idle_a(3);
      d = diff_a();
      tests_run++;
      if (d !== 0 || got_a.size() != 4) begin
         tests_failed++;
         $display("FAIL midreset_model: got %0d bad (%0d windows), required 0 bad of 4", d, got_a.size());
      end
   endtask

   task automatic test_random();
      int d;
      bit stop = 1'b0;
      clear_a();
      fork
         begin
            for (int f = 0; f < 10; f++) begin
               int h = int'($urandom_range(3, 6));
               int npix = h * WA;
               if ($urandom_range(0, 3) == 0) npix = int'($urandom_range(1, h * WA - 1));
               for (int n = 0; n < npix; n++) begin
                  drive_a(mk(int'($urandom), int'($urandom), int'($urandom)), n == 0,
                          n / WA, n % WA);
                  if ($urandom_range(0, 3) == 0) idle_a(int'($urandom_range(1, 3)));
               end
            end
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge clk);
               #1;
               a_out_ready = ($urandom_range(0, 1) == 1);
            end
            a_out_ready = 1'b1;
         end
      join
      idle_a(4);
      d = diff_a();
      tests_run++;
      if (d !== 0) begin
         tests_failed++;
         $display("FAIL random_model: got %0d bad (%0d seen, %0d expected), required 0",
                  d, got_a.size(), exp_a.size());
      end
   endtask

   task automatic test_wide();
      int bad = 0;
      int cmin = 65535;
      int cmax = 0;
      exp_b.delete();
      got_b.delete();
      for (int n = 0; n < 6 * WB; n++)
         drive_b(mk(int'($urandom), int'($urandom), int'($urandom)), n == 0, n / WB, n % WB);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      tests_run++;
      if (got_b.size() != 2 * (WB - KB + 1)) begin
         tests_failed++;
         $display("FAIL wide_count: got %0d windows, required %0d", got_b.size(), 2 * (WB - KB + 1));
      end
      if (got_b.size() > 0) begin
         tests_run++;
         if (got_b[0].row != 4 || got_b[0].col != 4 ||
             got_b[got_b.size()-1].row != 5 || got_b[got_b.size()-1].col != 639) begin
            tests_failed++;
            $display("FAIL wide_ends: got first (%0d,%0d) last (%0d,%0d), required (4,4) (5,639)",
                     got_b[0].row, got_b[0].col, got_b[got_b.size()-1].row,
                     got_b[got_b.size()-1].col);
         end
      end
      foreach (got_b[i]) begin
         if (got_b[i].col < cmin) cmin = got_b[i].col;
         if (got_b[i].col > cmax) cmax = got_b[i].col;
         if (i >= exp_b.size() || got_b[i].row != exp_b[i].row || got_b[i].col != exp_b[i].col ||
             got_b[i].win !== exp_b[i].win) bad++;
      end
      tests_run++;
      if (cmin != 4 || cmax != 639) begin
         tests_failed++;
         $display("FAIL wide_col_range: got %0d..%0d, required 4..639", cmin, cmax);
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL wide_windows: got %0d differing windows, required 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_backpressure();
      test_sof_restart();
      test_reset_mid();
      test_random();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
